// File: rtl/video_stream_pkg.sv
// Shared types and constants for the video frame sanitizer.
package video_stream_pkg;

    localparam int unsigned MIN_GEOM = 2;

    typedef enum logic [2:0] {
        WAIT_SOF,
        PASS,
        DROP_LINE,
        PAD_LINE,
        PAD_FRAME
    } state_t;

endpackage

// File: rtl/sanitizer_out_reg.sv
// One-entry registered output stage; accepts a new beat whenever the slot is free.
module sanitizer_out_reg #(
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               emit,
    input  logic [D_WIDTH-1:0] emit_data,
    input  logic               emit_tlast,
    input  logic               emit_tuser,
    input  logic               down_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    output logic               slot_free_c
);

    assign slot_free_c = !down_valid || down_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_data  <= '0;
            down_valid <= 1'b0;
            down_tlast <= 1'b0;
            down_tuser <= 1'b0;
        end else if (emit && slot_free_c) begin
            down_data  <= emit_data;
            down_valid <= 1'b1;
            down_tlast <= emit_tlast;
            down_tuser <= emit_tuser;
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/video_frame_sanitizer.sv
// Forces every frame to cfg_width x cfg_height: truncates long lines, pads short
// lines/frames, drops beats outside a frame, and reports each repair in sticky flags.
module video_frame_sanitizer
    import video_stream_pkg::*;
#(
    parameter int unsigned        D_WIDTH   = 8,
    parameter int unsigned        CNT_WIDTH = 12,
    parameter logic [D_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0] cfg_height,
    input  logic                 err_clr,
    input  logic [D_WIDTH-1:0]   up_data,
    input  logic                 up_valid,
    input  logic                 up_tlast,
    input  logic                 up_tuser,
    output logic                 up_ready,
    output logic [D_WIDTH-1:0]   down_data,
    output logic                 down_valid,
    output logic                 down_tlast,
    output logic                 down_tuser,
    input  logic                 down_ready,
    output logic                 err_short_line,
    output logic                 err_long_line,
    output logic                 err_early_sof,
    output logic                 err_no_sof
);

    localparam int unsigned CW = CNT_WIDTH;

    state_t state, state_nxt;
    logic [CW-1:0] pix_cnt, line_cnt, pix_nxt, line_nxt;
    logic [CW-1:0] w_lat, h_lat, w_cfg, h_cfg;
    logic [CW-1:0] pix_adv, line_adv;
    logic          at_sof, last_pix, last_line, frame_end;
    logic          slot_free, emit, emit_tlast, emit_tuser, latch, early;
    logic [D_WIDTH-1:0] emit_data;
    logic          set_short, set_long, set_early, set_no_sof;

    assign w_cfg = (cfg_width  < CW'(MIN_GEOM)) ? CW'(MIN_GEOM) : cfg_width;
    assign h_cfg = (cfg_height < CW'(MIN_GEOM)) ? CW'(MIN_GEOM) : cfg_height;

    assign at_sof    = (pix_cnt == '0) && (line_cnt == '0);
    assign last_pix  = (pix_cnt == w_lat - CW'(1));
    assign last_line = (line_cnt == h_lat - CW'(1));
    assign frame_end = last_pix && last_line;
    assign pix_adv   = last_pix ? '0 : pix_cnt + CW'(1);
    assign line_adv  = !last_pix ? line_cnt : (last_line ? '0 : line_cnt + CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WAIT_SOF;
            pix_cnt  <= '0;
            line_cnt <= '0;
            w_lat    <= CW'(MIN_GEOM);
            h_lat    <= CW'(MIN_GEOM);
        end else begin
            state    <= state_nxt;
            pix_cnt  <= pix_nxt;
            line_cnt <= line_nxt;
            if (latch) begin
                w_lat <= w_cfg;
                h_lat <= h_cfg;
            end
        end
    end

    // Next state, counters, emit request and repair events.
    always_comb begin
        state_nxt  = state;
        pix_nxt    = pix_cnt;
        line_nxt   = line_cnt;
        up_ready   = 1'b0;
        emit       = 1'b0;
        emit_data  = up_data;
        emit_tlast = last_pix;
        emit_tuser = at_sof;
        latch      = 1'b0;
        early      = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        set_early  = 1'b0;
        set_no_sof = 1'b0;

        case (state)
            WAIT_SOF: begin
                // Geometry is always >= 2, so the SOF pixel is never a line end.
                emit_tuser = 1'b1;
                emit_tlast = 1'b0;
                if (up_tuser) begin
                    up_ready = slot_free;
                    if (up_valid && slot_free) begin
                        emit     = 1'b1;
                        latch    = 1'b1;
                        pix_nxt  = CW'(1);
                        line_nxt = '0;
                        if (up_tlast) begin
                            set_short = 1'b1;
                            state_nxt = PAD_LINE;
                        end else begin
                            state_nxt = PASS;
                        end
                    end
                end else begin
                    up_ready   = 1'b1;
                    set_no_sof = up_valid;
                end
            end

            PASS: begin
                early    = up_valid && up_tuser && !at_sof;
                up_ready = slot_free && !early;
                if (early && slot_free) begin
                    set_early = 1'b1;
                    state_nxt = PAD_FRAME;
                end else if (up_valid && slot_free) begin
                    emit     = 1'b1;
                    pix_nxt  = pix_adv;
                    line_nxt = line_adv;
                    if (last_pix && !up_tlast) begin
                        set_long  = 1'b1;
                        state_nxt = DROP_LINE;
                    end else if (up_tlast && !last_pix) begin
                        emit_tlast = 1'b0;
                        set_short  = 1'b1;
                        state_nxt  = PAD_LINE;
                    end else if (frame_end) begin
                        state_nxt = WAIT_SOF;
                    end
                end
            end

            DROP_LINE: begin
                // Counters already point at the next line; frame start means the frame is done.
                up_ready = !up_tuser;
                if (up_valid && (up_tuser || up_tlast)) begin
                    state_nxt = at_sof ? WAIT_SOF : PASS;
                end
            end

            PAD_LINE: begin
                emit_data = PAD_VALUE;
                if (slot_free) begin
                    emit     = 1'b1;
                    pix_nxt  = pix_adv;
                    line_nxt = line_adv;
                    if (last_pix) begin
                        state_nxt = last_line ? WAIT_SOF : PASS;
                    end
                end
            end

            PAD_FRAME: begin
                emit_data = PAD_VALUE;
                if (slot_free) begin
                    emit     = 1'b1;
                    pix_nxt  = pix_adv;
                    line_nxt = line_adv;
                    if (frame_end) begin
                        state_nxt = WAIT_SOF;
                    end
                end
            end

            default: begin
                state_nxt = WAIT_SOF;
                pix_nxt   = '0;
                line_nxt  = '0;
            end
        endcase

        if (!rst) begin
            up_ready = 1'b0;
        end
    end

    // Sticky flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_early_sof  <= 1'b0;
            err_no_sof     <= 1'b0;
        end else begin
            err_short_line <= set_short  || (err_short_line && !err_clr);
            err_long_line  <= set_long   || (err_long_line  && !err_clr);
            err_early_sof  <= set_early  || (err_early_sof  && !err_clr);
            err_no_sof     <= set_no_sof || (err_no_sof     && !err_clr);
        end
    end

    sanitizer_out_reg #(
        .D_WIDTH (D_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .emit        (emit),
        .emit_data   (emit_data),
        .emit_tlast  (emit_tlast),
        .emit_tuser  (emit_tuser),
        .down_ready  (down_ready),
        .down_data   (down_data),
        .down_valid  (down_valid),
        .down_tlast  (down_tlast),
        .down_tuser  (down_tuser),
        .slot_free_c (slot_free)
    );

endmodule

// File: tb/tb_video_frame_sanitizer.sv
// Directed bench for video_frame_sanitizer at 4x2 geometry.
module tb_video_frame_sanitizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] cfg_width  = 12'd4;
    logic [11:0] cfg_height = 12'd2;
    logic        err_clr = 1'b0;
    logic [7:0]  up_data = '0;
    logic        up_valid = 1'b0;
    logic        up_tlast = 1'b0;
    logic        up_tuser = 1'b0;
    logic        up_ready;
    logic [7:0]  down_data;
    logic        down_valid;
    logic        down_tlast;
    logic        down_tuser;
    logic        down_ready = 1'b1;
    logic        err_short_line, err_long_line, err_early_sof, err_no_sof;

    int total = 0;
    int bad   = 0;
    bit toggle = 1'b0;
    logic [9:0] got_q[$];
    logic [9:0] ref_q[$];

    video_frame_sanitizer #(
        .D_WIDTH   (8),
        .CNT_WIDTH (12),
        .PAD_VALUE (8'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .err_clr        (err_clr),
        .up_data        (up_data),
        .up_valid       (up_valid),
        .up_tlast       (up_tlast),
        .up_tuser       (up_tuser),
        .up_ready       (up_ready),
        .down_data      (down_data),
        .down_valid     (down_valid),
        .down_tlast     (down_tlast),
        .down_tuser     (down_tuser),
        .down_ready     (down_ready),
        .err_short_line (err_short_line),
        .err_long_line  (err_long_line),
        .err_early_sof  (err_early_sof),
        .err_no_sof     (err_no_sof)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (down_valid && down_ready) got_q.push_back({down_tuser, down_tlast, down_data});
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (toggle) down_ready = ~down_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [9:0] px(input int d, input bit l = 1'b0, input bit u = 1'b0);
        return {u, l, 8'(d)};
    endfunction

    function automatic logic [3:0] errs();
        return {err_short_line, err_long_line, err_early_sof, err_no_sof};
    endfunction

    task automatic send(input int d, input bit last, input bit user);
        int n;
        up_data  = 8'(d);
        up_tlast = last;
        up_tuser = user;
        up_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (up_ready) break;
            n++;
            if (n > 60) begin
                chk("send_timeout", 32'(d), 32'hffff_ffff);
                break;
            end
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_tlast = 1'b0;
        up_tuser = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string tag);
        chk($sformatf("%s_len", tag), 32'(got_q.size()), 32'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(ref_q[i]));
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        idle(3);
        chk("rst_valid", 32'(down_valid), 0);
        chk("rst_ready", 32'(up_ready), 0);
        chk("rst_errs",  32'(errs()), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Clean frame
        got_q.delete();
        send(1, 0, 1);
        chk("lat_valid", 32'(down_valid), 1);
        chk("lat_data",  32'(down_data), 1);
        chk("lat_tuser", 32'(down_tuser), 1);
        send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0); send(8, 1, 0);
        idle(4);
        ref_q = '{px(1,0,1), px(2), px(3), px(4,1), px(5), px(6), px(7), px(8,1)};
        cmp_q("clean");
        chk("clean_errs", 32'(errs()), 0);

        // Long line then clean line
        got_q.delete();
        send(1, 0, 1); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0); send(5, 1, 0);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        idle(4);
        ref_q = '{px(1,0,1), px(2), px(3), px(4,1), px(1), px(2), px(3), px(4,1)};
        cmp_q("long");
        chk("long_errs", 32'(errs()), 32'h4);
        clear_errs();
        chk("long_clr", 32'(errs()), 0);

        // Short line padded
        got_q.delete();
        send(1, 0, 1); send(2, 1, 0);
        @(negedge clk); chk("pad_rdy0", 32'(up_ready), 0);
        @(negedge clk); chk("pad_rdy1", 32'(up_ready), 0);
        @(negedge clk); chk("pad_rdy2", 32'(up_ready), 1);
        @(posedge clk); #1;
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0); send(8, 1, 0);
        idle(4);
        ref_q = '{px(1,0,1), px(2), px(0), px(0,1), px(5), px(6), px(7), px(8,1)};
        cmp_q("short");
        chk("short_errs", 32'(errs()), 32'h8);
        clear_errs();

        // Early SOF pads out the frame
        got_q.delete();
        send(1, 0, 1); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0); send(5, 0, 0);
        send(11, 0, 1); send(12, 0, 0); send(13, 0, 0); send(14, 1, 0);
        send(15, 0, 0); send(16, 0, 0); send(17, 0, 0); send(18, 1, 0);
        idle(4);
        ref_q = '{px(1,0,1), px(2), px(3), px(4,1), px(5), px(0), px(0), px(0,1),
                  px(11,0,1), px(12), px(13), px(14,1), px(15), px(16), px(17), px(18,1)};
        cmp_q("early");
        chk("early_errs", 32'(errs()), 32'h2);
        clear_errs();

        // Stray beats before SOF, set wins over a simultaneous clear
        got_q.delete();
        send(9, 0, 0);
        err_clr = 1'b1;
        send(9, 0, 0);
        err_clr = 1'b0;
        idle(3);
        chk("nosof_len", 32'(got_q.size()), 0);
        chk("nosof_errs", 32'(errs()), 32'h1);
        clear_errs();
        chk("nosof_clr", 32'(errs()), 0);

        // Downstream backpressure toggling every cycle
        got_q.delete();
        toggle = 1'b1;
        send(1, 0, 1); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        send(5, 0, 0); send(6, 0, 0); send(7, 0, 0); send(8, 1, 0);
        idle(6);
        toggle = 1'b0;
        idle(1);
        down_ready = 1'b1;
        idle(4);
        ref_q = '{px(1,0,1), px(2), px(3), px(4,1), px(5), px(6), px(7), px(8,1)};
        cmp_q("bp");
        chk("bp_errs", 32'(errs()), 0);

        // Reset mid-line, then a frame without SOF is dropped
        send(1, 0, 1); send(2, 0, 0);
        err_clr = 1'b0;
        rst = 1'b0;
        #1;
        chk("mrst_valid", 32'(down_valid), 0);
        chk("mrst_data",  32'(down_data), 0);
        chk("mrst_ready", 32'(up_ready), 0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        got_q.delete();
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        send(5, 0, 1); send(6, 0, 0); send(7, 0, 0); send(8, 1, 0);
        send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 1, 0);
        idle(4);
        ref_q = '{px(5,0,1), px(6), px(7), px(8,1), px(1), px(2), px(3), px(4,1)};
        cmp_q("mrst");
        chk("mrst_errs", 32'(errs()), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_frame_sanitizer.md
Name: video_frame_sanitizer

Overview:
- Geometry-enforcing stage placed directly upstream of the 2x2 downscaler top (rtl_top). It drives that block's up_data/up_valid/up_tlast/up_tuser and takes its up_ready.
- Guarantees every frame passed downstream has exactly cfg_width pixels per line and cfg_height lines per frame.
  - tuser marks the first pixel of a frame.
  - tlast marks the last pixel of a line.
- Malformed input is repaired: long lines truncated, short lines and short frames padded, stray beats dropped.
- Sticky error flags report each repair.

Parameters:
- D_WIDTH, 8, pixel data width.
- CNT_WIDTH, 12, width of the pixel and line counters and of the cfg ports.
- PAD_VALUE, 0, pixel value emitted for inserted pixels (D_WIDTH bits).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_width  in  CNT_WIDTH  active pixels per line; latched on SOF acceptance.
- cfg_height  in  CNT_WIDTH  active lines per frame; latched on SOF acceptance.
- err_clr  in  1  synchronous clear of all err_* flags.
- up_data  in  D_WIDTH  input pixel.
- up_valid  in  1  input beat valid.
- up_tlast  in  1  input end of line.
- up_tuser  in  1  input start of frame.
- up_ready  out  1  input beat accepted when up_valid && up_ready.
- down_data  out  D_WIDTH  output pixel (registered).
- down_valid  out  1  output beat valid (registered).
- down_tlast  out  1  output end of line (registered).
- down_tuser  out  1  output start of frame (registered).
- down_ready  in  1  downstream ready.
- err_short_line  out  1  sticky: line padded.
- err_long_line  out  1  sticky: line truncated.
- err_early_sof  out  1  sticky: frame padded because SOF arrived mid-frame.
- err_no_sof  out  1  sticky: beat dropped while waiting for SOF.

Behaviour:
- Reset, and the whole time rst=0:
  - down_valid/down_data/down_tlast/down_tuser = 0.
  - all err_* = 0; pix_cnt = line_cnt = 0.
  - state = WAIT_SOF; up_ready = 0.
- Output register (one-entry):
  - slot_free = !down_valid || down_ready.
  - Loads when an emit occurs and slot_free.
  - down_valid clears when down_ready and no new emit.
  - Latency: accepted beat appears on down_* the next cycle. Full throughput, no bubbles.
- Effective geometry W/H = latched cfg values, each clamped to a minimum of 2. Values must be even for the downstream block; not checked here.
- Emitted tuser = (pix_cnt==0 && line_cnt==0). Emitted tlast = (pix_cnt==W-1).
- Counter advance on every emit:
  - pix_cnt wraps at W-1.
  - line_cnt increments on wrap.
  - Wrap of the last line (line_cnt==H-1) → state WAIT_SOF, both counters reset to 0.
- WAIT_SOF:
  - up_ready=1 for beats with tuser=0 (dropped, not emitted; set err_no_sof).
  - A tuser=1 beat: accepted only when slot_free. Latch cfg, emit it, go to PASS.
  - If that beat also has tlast=1, treat it as a short line: emit with tlast=0, go to PAD_LINE, set err_short_line.
- PASS:
  - up_ready = slot_free && !early, where early = up_valid && up_tuser && !(pix_cnt==0 && line_cnt==0). up_ready may depend on up_valid/up_tuser.
  - early=1: beat not consumed; set err_early_sof; go to PAD_FRAME.
  - Accepted beat, pix_cnt==W-1 && !up_tlast: emit with tlast=1; set err_long_line; go to DROP_LINE.
  - Accepted beat, up_tlast && pix_cnt<W-1: emit with tlast=0; set err_short_line; go to PAD_LINE.
  - Otherwise: emit unchanged data with generated tuser/tlast.
- DROP_LINE:
  - up_ready=1; beats discarded, nothing emitted.
  - On the accepted beat with tlast: go to PASS, or to WAIT_SOF if the truncated line was the last line.
  - An up_tuser beat in DROP_LINE is not consumed: go directly to PASS at line start, or WAIT_SOF if at frame start. Next-line/frame logic then handles it.
- PAD_LINE:
  - up_ready=0; emit PAD_VALUE each slot_free cycle until tlast emitted.
  - Then go to PASS, or WAIT_SOF after the last line.
- PAD_FRAME:
  - up_ready=0; emit PAD_VALUE until the last pixel of line H-1, then WAIT_SOF.
  - The pending SOF beat is then accepted normally.
- err_* flags: set-priority over err_clr when both occur in the same cycle; otherwise err_clr clears them. Flags never self-clear.
- Backpressure: with down_ready=0 and down_valid=1, no state, counter or flag change, except drops in WAIT_SOF/DROP_LINE, which do not need the output slot.
- cfg changes mid-frame have no effect until the next SOF acceptance.

Decomposition:
- Package video_stream_pkg holds:
  - state enum (WAIT_SOF, PASS, DROP_LINE, PAD_LINE, PAD_FRAME);
  - the minimum-geometry constant (2).
- One sub-module: sanitizer_out_reg, the one-entry registered output stage with slot_free. The FSM, counters and flags stay in the top.

Test Plan (W=4, H=2, PAD_VALUE=0, down_ready=1 unless noted):
- Clean frame 1..8, tlast on 4 and 8, tuser on 1 → identical output at 1-cycle latency; all err_*=0.
- Line 1..5, tlast only on 5 → output 1,2,3,4 (tlast on 4); 5 dropped; err_long_line=1; next line passes clean.
- Line 1,2 with tlast on 2 → output 1,2,0,0 (tlast on last 0); up_ready=0 for 2 cycles; err_short_line=1.
- New tuser beat after 5 pixels of a frame → output 5 real pixels + 3 pad pixels (frame total 8); err_early_sof=1; new frame then starts with tuser=1.
- Beats 9,9 (no tuser) before SOF → dropped; err_no_sof=1; err_clr pulse → 0.
- Clean frame with down_ready toggling 1/0 every cycle → no data loss or duplication; output sequence 1..8 unchanged.
- rst asserted mid-line → all outputs 0 immediately; after release a frame without a preceding SOF is dropped until tuser.
